// File: rtl/uart_pkg.sv
// Shared opcodes, response bytes and parser state
// encoding for the UART command responder.
package uart_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    SEND,
    WAIT_TX
  } state_e;

endpackage

// File: rtl/uart_regfile.sv
// DEPTH x 8 register file: async reset, one write
// port, one combinational read port.
module uart_regfile
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command parser: 'W' addr data / 'R' addr,
// one response byte per command via the UART TX side.
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int         DEPTH          = 16,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] RESET_VAL      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  input  logic       tx_rdy,
  output logic       busy,
  output logic [7:0] cmd_count,
  output logic [7:0] drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] DEPTH_V = 9'(DEPTH);

  state_e        state_q;
  logic          rdy_q;
  logic [7:0]    op_q;
  logic [7:0]    addr_q;
  logic [CW-1:0] to_q;
  logic [7:0]    tx_data_q;
  logic          wr_en_q;
  logic [7:0]    cmd_q;
  logic [7:0]    drop_q;

  logic       rx_stb;
  logic       rx_ok;
  logic       addr_ok;
  logic       rf_we;
  logic [7:0] rf_rdata;
  logic       in_tx;

  assign rx_stb  = rx_rdy & ~rdy_q;
  assign rx_ok   = {1'b0, rx_data} < DEPTH_V;
  assign addr_ok = {1'b0, addr_q} < DEPTH_V;
  assign in_tx   = (state_q == SEND) ||
                   (state_q == WAIT_TX);
  assign rf_we   = (state_q == GET_DATA) &&
                   rx_stb && addr_ok;

  uart_regfile #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we),
    .waddr_i (addr_q[AW-1:0]),
    .wdata_i (rx_data),
    .raddr_i (rx_data[AW-1:0]),
    .rdata_o (rf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b1;
      op_q      <= '0;
      addr_q    <= '0;
      to_q      <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      cmd_q     <= '0;
      drop_q    <= '0;
    end else begin
      rdy_q   <= rx_rdy;
      wr_en_q <= 1'b0;
      if (rx_stb && in_tx && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (rx_stb) begin
            if (rx_data == OP_WR ||
                rx_data == OP_RD) begin
              op_q    <= rx_data;
              to_q    <= '0;
              state_q <= GET_ADDR;
            end else begin
              tx_data_q <= RSP_ERR;
              state_q   <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_stb) begin
            to_q   <= '0;
            addr_q <= rx_data;
            if (op_q == OP_WR) begin
              state_q <= GET_DATA;
            end else begin
              tx_data_q <= rx_ok ? rf_rdata : RSP_ERR;
              state_q   <= SEND;
            end
          end else if (to_q == TO_LAST) begin
            to_q    <= '0;
            state_q <= IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_stb) begin
            to_q      <= '0;
            tx_data_q <= addr_ok ? RSP_OK : RSP_ERR;
            state_q   <= SEND;
          end else if (to_q == TO_LAST) begin
            to_q    <= '0;
            state_q <= IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        SEND: begin
          if (tx_rdy) begin
            wr_en_q <= 1'b1;
            state_q <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (!tx_rdy) begin
            cmd_q   <= cmd_q + 8'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_wr_en   = wr_en_q;
  assign busy       = (state_q != IDLE);
  assign cmd_count  = cmd_q;
  assign drop_count = drop_q;

endmodule
